// File: rtl/pe_gating_pkg.sv
// Shared types and default timing constants for the PE clock-gating logic.
// The gating cell's bench uses the same defaults, so keep them in one place.
package pe_gating_pkg;

    typedef enum logic [1:0] {
        GC_OFF,
        GC_WAKE,
        GC_ON,
        GC_COOL
    } gc_state_t;

    localparam int GC_IDLE_TIMEOUT_DEF = 16;
    localparam int GC_WAKE_CYCLES_DEF  = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear, hold and increment controls.
// Priority is clear, then hold, then increment; the count stops at MAX.
module sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         hold,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // Count register: clear wins, hold freezes, increment stops at MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (hold) begin
            cnt <= cnt;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pe_clk_gate_ctrl.sv
// Activity monitor and start/finish sequencer for the PE self-gating cell.
// Runs on the free-running clock; masks upstream ready while the PE clock
// is waking up or shutting down.
module pe_clk_gate_ctrl
    import pe_gating_pkg::*;
#(
    parameter int IDLE_TIMEOUT = GC_IDLE_TIMEOUT_DEF,
    parameter int WAKE_CYCLES  = GC_WAKE_CYCLES_DEF,
    parameter int CNT_W        = $clog2(IDLE_TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             pe_busy,
    input  logic             force_on,
    output logic             start,
    output logic             finish,
    output logic             req_ready_en,
    output logic             clk_on,
    output logic [CNT_W-1:0] idle_cnt
);

    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

    gc_state_t         state;
    gc_state_t         state_nxt;
    logic              act;
    logic [WAKE_W-1:0] wake_cnt;
    logic              finish_q;
    logic              idle_clr;
    logic              idle_hold;
    logic              idle_inc;
    logic              wake_clr;

    assign act = req_valid | pe_busy | force_on;

    // Idle count restarts on any activity and outside ON/COOL; COOL freezes it.
    assign idle_clr  = act || (state == GC_OFF) || (state == GC_WAKE);
    assign idle_hold = (state == GC_COOL);
    assign idle_inc  = (state == GC_ON);

    // Wake counter runs only while in WAKE, starting at 0 on the start cycle.
    assign wake_clr = (state != GC_WAKE);

    sat_counter #(
        .W   (CNT_W),
        .MAX (IDLE_TIMEOUT)
    ) u_idle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (idle_clr),
        .hold  (idle_hold),
        .inc   (idle_inc),
        .cnt   (idle_cnt)
    );

    sat_counter #(
        .W   (WAKE_W),
        .MAX (WAKE_CYCLES)
    ) u_wake_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wake_clr),
        .hold  (1'b0),
        .inc   (1'b1),
        .cnt   (wake_cnt)
    );

    // State register; reset drops straight to OFF without a finish pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= GC_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode for the OFF -> WAKE -> ON -> COOL -> OFF cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            GC_OFF: begin
                if (act) state_nxt = GC_WAKE;
            end
            GC_WAKE: begin
                if (wake_cnt == WAKE_W'(WAKE_CYCLES - 1)) state_nxt = GC_ON;
            end
            GC_ON: begin
                if (!act && (idle_cnt == CNT_W'(IDLE_TIMEOUT - 1))) state_nxt = GC_COOL;
            end
            GC_COOL: begin
                state_nxt = act ? GC_ON : GC_OFF;
            end
            default: state_nxt = GC_OFF;
        endcase
    end

    // Finish is registered so it lands in the first OFF cycle after COOL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finish_q <= 1'b0;
        end else begin
            finish_q <= (state == GC_COOL) && !act;
        end
    end

    assign start        = (state == GC_WAKE) && (wake_cnt == '0);
    assign finish       = finish_q;
    assign req_ready_en = (state == GC_ON);
    assign clk_on       = (state != GC_OFF);

endmodule

// File: tb/tb_pe_clk_gate_ctrl.sv
// Directed, table-driven bench for pe_clk_gate_ctrl with IDLE_TIMEOUT=4,
// WAKE_CYCLES=2. Cycle k starts at the k-th rising edge after reset release.
module tb_pe_clk_gate_ctrl;

    localparam int TB_IT    = 4;
    localparam int TB_WAKE  = 2;
    localparam int TB_CNT_W = 3;
    localparam int NVEC     = 21;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                pe_busy;
    logic                force_on;
    logic                start;
    logic                finish;
    logic                req_ready_en;
    logic                clk_on;
    logic [TB_CNT_W-1:0] idle_cnt;

    int checks;
    int failures;

    typedef struct {
        logic                rv;
        logic                pb;
        logic                fo;
        logic                e_start;
        logic                e_finish;
        logic                e_rdy;
        logic                e_on;
        bit                  chk_idle;
        logic [TB_CNT_W-1:0] e_idle;
    } vec_t;

    vec_t vecs [NVEC];

    pe_clk_gate_ctrl #(
        .IDLE_TIMEOUT (TB_IT),
        .WAKE_CYCLES  (TB_WAKE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .pe_busy      (pe_busy),
        .force_on     (force_on),
        .start        (start),
        .finish       (finish),
        .req_ready_en (req_ready_en),
        .clk_on       (clk_on),
        .idle_cnt     (idle_cnt)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the stimulus.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compareVal(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic compareNow(input string name, input logic e_start, input logic e_finish,
                              input logic e_rdy, input logic e_on, input bit chk_idle,
                              input logic [TB_CNT_W-1:0] e_idle);
        compareVal({name, ".start"}, {7'd0, start}, {7'd0, e_start});
        compareVal({name, ".finish"}, {7'd0, finish}, {7'd0, e_finish});
        compareVal({name, ".req_ready_en"}, {7'd0, req_ready_en}, {7'd0, e_rdy});
        compareVal({name, ".clk_on"}, {7'd0, clk_on}, {7'd0, e_on});
        if (chk_idle) compareVal({name, ".idle_cnt"}, {5'd0, idle_cnt}, {5'd0, e_idle});
    endtask

    // Sample outputs mid-cycle, away from the active edge.
    task automatic checkOutput(input string name, input logic e_start, input logic e_finish,
                               input logic e_rdy, input logic e_on, input bit chk_idle,
                               input logic [TB_CNT_W-1:0] e_idle);
        @(negedge clk);
        compareNow(name, e_start, e_finish, e_rdy, e_on, chk_idle, e_idle);
    endtask

    // Start a new cycle and drive its inputs just after the rising edge.
    task automatic applyStimulus(input logic rv, input logic pb, input logic fo);
        @(posedge clk);
        #1;
        req_valid = rv;
        pe_busy   = pb;
        force_on  = fo;
    endtask

    task automatic doReset();
        req_valid = 1'b0;
        pe_busy   = 1'b0;
        force_on  = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic setVec(input int i, input logic rv, input logic pb, input logic fo,
                          input logic es, input logic ef, input logic er, input logic eo,
                          input bit ci, input logic [TB_CNT_W-1:0] ei);
        vecs[i].rv       = rv;
        vecs[i].pb       = pb;
        vecs[i].fo       = fo;
        vecs[i].e_start  = es;
        vecs[i].e_finish = ef;
        vecs[i].e_rdy    = er;
        vecs[i].e_on     = eo;
        vecs[i].chk_idle = ci;
        vecs[i].e_idle   = ei;
    endtask

    // Replay the wake/sleep table from cycle 0 through cycle lastIdx.
    task automatic runTable(input int lastIdx);
        for (int i = 0; i <= lastIdx; i++) begin
            applyStimulus(vecs[i].rv, vecs[i].pb, vecs[i].fo);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_start, vecs[i].e_finish,
                        vecs[i].e_rdy, vecs[i].e_on, vecs[i].chk_idle, vecs[i].e_idle);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        pe_busy   = 1'b0;
        force_on  = 1'b0;

        //           cyc rv pb fo  st fin rdy on  chk idle
        for (int i = 0; i < 5; i++) setVec(i, 0, 0, 0, 0, 0, 0, 0, 1, 3'd0);
        setVec( 5, 1, 0, 0,  0, 0, 0, 0,  1, 3'd0);
        setVec( 6, 1, 0, 0,  1, 0, 0, 1,  1, 3'd0);
        setVec( 7, 0, 1, 0,  0, 0, 0, 1,  1, 3'd0);
        setVec( 8, 1, 0, 0,  0, 0, 1, 1,  1, 3'd0);
        setVec( 9, 0, 1, 0,  0, 0, 1, 1,  1, 3'd0);
        setVec(10, 0, 0, 1,  0, 0, 1, 1,  1, 3'd0);
        setVec(11, 0, 0, 0,  0, 0, 1, 1,  1, 3'd0);
        setVec(12, 0, 0, 0,  0, 0, 1, 1,  1, 3'd1);
        setVec(13, 0, 0, 0,  0, 0, 1, 1,  1, 3'd2);
        setVec(14, 0, 0, 0,  0, 0, 1, 1,  1, 3'd3);
        setVec(15, 0, 0, 0,  0, 0, 0, 1,  0, 3'd0);
        setVec(16, 0, 0, 0,  0, 1, 0, 0,  0, 3'd0);
        for (int i = 17; i < NVEC; i++) setVec(i, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0);

        // Reset state, then 20 quiet cycles with nothing waking up.
        #2;
        compareNow("in_reset", 0, 0, 0, 0, 1, 3'd0);
        doReset();
        for (int c = 0; c < 20; c++) begin
            applyStimulus(0, 0, 0);
            checkOutput($sformatf("quiet%0d", c), 0, 0, 0, 0, 1, 3'd0);
        end

        // Wake on req_valid in cycle 5, sleep after last activity in cycle 10.
        doReset();
        runTable(NVEC - 1);

        // COOL abort: pe_busy during COOL returns to ON with no finish.
        doReset();
        runTable(14);
        applyStimulus(0, 1, 0);
        checkOutput("abort_cool", 0, 0, 0, 1, 0, 3'd0);
        applyStimulus(0, 0, 0);
        checkOutput("abort_on", 0, 0, 1, 1, 1, 3'd0);
        applyStimulus(0, 0, 0);
        checkOutput("abort_idle1", 0, 0, 1, 1, 1, 3'd1);
        applyStimulus(0, 0, 0);
        checkOutput("abort_idle2", 0, 0, 1, 1, 1, 3'd2);

        // Back-to-back: req_valid in the finish cycle restarts immediately.
        doReset();
        runTable(15);
        applyStimulus(1, 0, 0);
        checkOutput("b2b_finish", 0, 1, 0, 0, 0, 3'd0);
        applyStimulus(0, 0, 0);
        checkOutput("b2b_start", 1, 0, 0, 1, 1, 3'd0);
        applyStimulus(0, 0, 0);
        checkOutput("b2b_wake2", 0, 0, 0, 1, 1, 3'd0);
        applyStimulus(0, 0, 0);
        checkOutput("b2b_on", 0, 0, 1, 1, 1, 3'd0);

        // Reset asserted in ON cycle 9: outputs clear at once, no finish later.
        doReset();
        runTable(8);
        applyStimulus(1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        compareNow("rst_mid_now", 0, 0, 0, 0, 1, 3'd0);
        req_valid = 1'b0;
        for (int c = 0; c < 2; c++) checkOutput($sformatf("rst_mid_hold%0d", c), 0, 0, 0, 0, 1, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 0, 0);
            checkOutput($sformatf("rst_mid_after%0d", c), 0, 0, 0, 0, 1, 3'd0);
        end

        // force_on held for 100 cycles keeps ON with idle count at 0.
        doReset();
        for (int c = 0; c < 100; c++) begin
            applyStimulus(0, 0, 1);
            if (c == 0)      checkOutput("force_c0", 0, 0, 0, 0, 1, 3'd0);
            else if (c == 1) checkOutput("force_c1", 1, 0, 0, 1, 1, 3'd0);
            else if (c == 2) checkOutput("force_c2", 0, 0, 0, 1, 1, 3'd0);
            else             checkOutput($sformatf("force_c%0d", c), 0, 0, 1, 1, 1, 3'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
